mem_stage: RTL
==============

Name: mem_stage

Overview:
- Pipeline MEM stage plus MEM/WB pipeline register of the P6 five-stage MIPS core.
- Takes the EX/MEM bundle and performs the data-memory access: word, half and byte stores; sign/zero-extended loads.
- Registers the results into the WB-side bundle (Instr_WB, ALUout_WB, DM_RD_WB, PC8_WB) consumed by the writeback stage.
- Contains the data-memory array.

Parameters:
- DM_WORDS, 3072, data-memory depth in 32-bit words.
- DM_AW, 12, word-index width; must satisfy 2^DM_AW >= DM_WORDS.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- Instr_MEM  input  32  instruction currently in MEM
- PC_MEM  input  32  PC of that instruction (write log only)
- PC8_MEM  input  32  PC+8 link value
- ALUout_MEM  input  32  ALU result / effective address
- WriteData_MEM  input  32  store data (rt), already forwarded
- Instr_WB  output  32  registered instruction
- ALUout_WB  output  32  registered ALU result
- DM_RD_WB  output  32  registered, extended load data
- PC8_WB  output  32  registered PC+8

Behaviour:
- Reset (asynchronous, active-high):
  - all four WB outputs go to 32'h0 immediately; Instr_WB=0 decodes as nop (sll $0), so no RF write.
  - every memory word is cleared to 0.
  - reset released mid-stream: the first edge after release captures the current MEM bundle normally.
- Decode from Instr_MEM[31:26]:
  - stores: sw 101011, sh 101001, sb 101000.
  - loads: lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100.
  - any other opcode: no memory access; DM_RD_WB captures 0.
- Addressing: word index = ALUout_MEM[DM_AW+1:2]; higher bits ignored (aliasing). Index >= DM_WORDS: store dropped, load returns 0.
- Store byte enables, applied at the rising clk edge:
  - sw: all four bytes.
  - sh: addr[1]=0 -> bytes 1:0 get WD[15:0]; addr[1]=1 -> bytes 3:2 get WD[15:0].
  - sb: byte addr[1:0] gets WD[7:0].
  - untouched bytes keep their value.
- Misaligned accesses (no exceptions in P6):
  - sw with addr[1:0]!=0, or sh with addr[0]=1: store suppressed.
  - misaligned loads return 0.
- Load path:
  - combinational read of the addressed word.
  - byte/half selected by addr[1:0] / addr[1].
  - sign-extend for lh/lb, zero-extend for lhu/lbu.
  - result registered into DM_RD_WB at the edge.
- Latency: one cycle, MEM bundle -> WB bundle. No stall or flush inputs; the register loads every cycle.
- Read-after-write: a store at edge N followed by a load to the same address in MEM during cycle N+1 returns the updated data. No bypass is needed, since only one instruction occupies MEM per cycle.
- Pass-through: Instr_WB, ALUout_WB and PC8_WB are the edge-captured copies of Instr_MEM, ALUout_MEM and PC8_MEM, unmodified.

Optional Feature:
- Macro DM_WRITE_LOG_EN.
- Defined: on every performed store, the simulation prints `@<PC_MEM hex8>: *<word-aligned byte address hex8> <= <full post-write word hex8>`. Suppressed stores print nothing.
- Undefined: no print statements are compiled; PC_MEM is unused.

Decomposition:
- Shared defines header: opcode constants (OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB), the same ones ctrl decodes.
- Sub-module dm_ram holds:
  - the array with byte-enable write.
  - asynchronous clear.
  - combinational word read.
  - the optional log.
- mem_stage holds decode, byte-enable generation, load extension and the MEM/WB register.

Test Plan:
- Reset pulse mid-run -> all WB outputs 0 immediately; a subsequent lw from 0x0 returns 0.
- sw 0x89ABCDEF @0x10, then lw @0x10 -> DM_RD_WB=0x89ABCDEF one cycle after the load enters MEM. With DM_WRITE_LOG_EN, the log shows `*00000010 <= 89abcdef`.
- sb 0x7F @0x13, then lb @0x13 -> 0x0000007F. Then sb 0x80 @0x12; lb @0x12 -> 0xFFFFFF80, lbu @0x12 -> 0x00000080, lw @0x10 -> 0x7F80CDEF.
- sh 0x8001 @0x22; lh -> 0xFFFF8001; lhu -> 0x00008001. Then sh @0x21 (misaligned) -> memory unchanged, no log line.
- Back-to-back: addu, jal, lw -> WB bundle reproduces each Instr/ALUout/PC8 exactly one cycle later; DM_RD_WB=0 for the non-loads.
- Aliasing: sw 0x1 @0x0000_4000 with DM_AW=12 -> lw @0x0 returns 0x1.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared opcode constants, default memory geometry and the MEM-stage opcode decoder.
// Included by mem_stage and dm_ram via import mem_stage_pkg::*.
package mem_stage_pkg;

  localparam int DM_WORDS_DEF = 3072;
  localparam int DM_AW_DEF    = 12;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_t;

  typedef struct packed {
    logic      is_load;
    logic      is_store;
    acc_size_t size;
    logic      sext;
  } mem_dec_t;

  function automatic mem_dec_t decode_op(input logic [5:0] op);
    mem_dec_t d;
    d = '{is_load: 1'b0, is_store: 1'b0, size: SZ_WORD, sext: 1'b0};
    case (op)
      OP_LW:  begin d.is_load  = 1'b1; d.size = SZ_WORD;                end
      OP_LH:  begin d.is_load  = 1'b1; d.size = SZ_HALF; d.sext = 1'b1; end
      OP_LHU: begin d.is_load  = 1'b1; d.size = SZ_HALF;                end
      OP_LB:  begin d.is_load  = 1'b1; d.size = SZ_BYTE; d.sext = 1'b1; end
      OP_LBU: begin d.is_load  = 1'b1; d.size = SZ_BYTE;                end
      OP_SW:  begin d.is_store = 1'b1; d.size = SZ_WORD;                end
      OP_SH:  begin d.is_store = 1'b1; d.size = SZ_HALF;                end
      OP_SB:  begin d.is_store = 1'b1; d.size = SZ_BYTE;                end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_stage_dm_ram.sv
// Data memory: byte-enable write, async clear, combinational word read.
// Optional write log enabled by defining DM_WRITE_LOG_EN.
module dm_ram
  import mem_stage_pkg::*;
#(
  parameter int DM_WORDS = DM_WORDS_DEF,
  parameter int DM_AW    = DM_AW_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic [31:0] rdata
);

  localparam logic [DM_AW:0] LIMIT = (DM_AW + 1)'(DM_WORDS);

  logic [31:0]      mem [DM_WORDS];
  logic [DM_AW-1:0] idx;
  logic             in_range;
  logic [31:0]      merged;
  logic             write_en;

  // Upper address bits are ignored, so addresses alias every 2^(DM_AW+2) bytes.
  assign idx      = addr[DM_AW+1:2];
  assign in_range = ({1'b0, idx} < LIMIT);
  assign rdata    = in_range ? mem[idx] : 32'h0;
  assign write_en = (|be) && in_range;

  always_comb begin
    merged = rdata;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merged[8*b +: 8] = wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DM_WORDS; i++) mem[i] <= 32'h0;
    end else if (write_en) begin
      mem[idx] <= merged;
    end
  end

`ifdef DM_WRITE_LOG_EN
  always_ff @(posedge clk) begin
    if (!rst && write_en)
      $display("@%08h: *%08h <= %08h", pc, {addr[31:2], 2'b00}, merged);
  end
`else
  logic unused_log;
  assign unused_log = ^{pc, addr[31:DM_AW+2], addr[1:0]};
`endif

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the P6 MIPS core: store byte-enables, load extraction/extension,
// and the MEM/WB register. Optional store log via DM_WRITE_LOG_EN (in dm_ram).
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DM_WORDS = DM_WORDS_DEF,
  parameter int DM_AW    = DM_AW_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr_MEM,
  input  logic [31:0] PC_MEM,
  input  logic [31:0] PC8_MEM,
  input  logic [31:0] ALUout_MEM,
  input  logic [31:0] WriteData_MEM,
  output logic [31:0] Instr_WB,
  output logic [31:0] ALUout_WB,
  output logic [31:0] DM_RD_WB,
  output logic [31:0] PC8_WB
);

  mem_dec_t    dec;
  logic [1:0]  a;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rword;
  logic [31:0] ld_data;
  logic [15:0] half;
  logic [7:0]  byt;

  assign dec = decode_op(Instr_MEM[31:26]);
  assign a   = ALUout_MEM[1:0];

  // Misaligned stores leave be at zero, which suppresses the write entirely.
  always_comb begin
    be    = 4'b0000;
    wdata = WriteData_MEM;
    if (dec.is_store) begin
      case (dec.size)
        SZ_WORD: if (a == 2'b00) be = 4'b1111;
        SZ_HALF: begin
          wdata = {2{WriteData_MEM[15:0]}};
          if (!a[0]) be = a[1] ? 4'b1100 : 4'b0011;
        end
        SZ_BYTE: begin
          wdata = {4{WriteData_MEM[7:0]}};
          be    = 4'b0001 << a;
        end
        default: ;
      endcase
    end
  end

  dm_ram #(
    .DM_WORDS(DM_WORDS),
    .DM_AW   (DM_AW)
  ) u_dm (
    .clk  (clk),
    .rst  (reset),
    .addr (ALUout_MEM),
    .be   (be),
    .wdata(wdata),
    .pc   (PC_MEM),
    .rdata(rword)
  );

  always_comb begin
    ld_data = 32'h0;
    half    = a[1] ? rword[31:16] : rword[15:0];
    case (a)
      2'd0:    byt = rword[7:0];
      2'd1:    byt = rword[15:8];
      2'd2:    byt = rword[23:16];
      default: byt = rword[31:24];
    endcase
    if (dec.is_load) begin
      case (dec.size)
        SZ_WORD: if (a == 2'b00) ld_data = rword;
        SZ_HALF: if (!a[0]) ld_data = dec.sext ? {{16{half[15]}}, half} : {16'h0, half};
        SZ_BYTE: ld_data = dec.sext ? {{24{byt[7]}}, byt} : {24'h0, byt};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Instr_WB  <= 32'h0;
      ALUout_WB <= 32'h0;
      DM_RD_WB  <= 32'h0;
      PC8_WB    <= 32'h0;
    end else begin
      Instr_WB  <= Instr_MEM;
      ALUout_WB <= ALUout_MEM;
      DM_RD_WB  <= ld_data;
      PC8_WB    <= PC8_MEM;
    end
  end

endmodule
